uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Advances one bit per bps_clk tick; all outputs are registered.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bps_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_en,
    output logic                 txd,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       ODD_BIT   = (PARITY_ODD != 0);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);

    state_t               state;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_cnt;
    logic                 parity_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
            txd      <= 1'b1;
            uart_en  <= 1'b0;
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shift_q  <= tx_data;
                        parity_q <= (^tx_data) ^ ODD_BIT;
                        state    <= START;
                        txd      <= 1'b0;
                        uart_en  <= 1'b1;
                        tx_ready <= 1'b0;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end

                START: begin
                    if (bps_clk) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        txd     <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end

                DATA: begin
                    if (bps_clk) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                state <= PARITY;
                                txd   <= parity_q;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end

                PARITY: begin
                    if (bps_clk) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        txd     <= 1'b1;
                    end
                end

                STOP: begin
                    if (bps_clk) begin
                        if (bit_cnt == LAST_STOP) begin
                            state    <= IDLE;
                            tx_done  <= 1'b1;
                            uart_en  <= 1'b0;
                            tx_ready <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
